ycbcr2rgb: RTL and testbench
============================

Name: ycbcr2rgb

Overview:
- Inverse of the team's RGB->YCbCr colour-space stage. Converts a 24-bit full-range YCbCr 4:4:4 video stream back to 24-bit RGB.
- Sits in the video pipeline between the processing blocks that work in YCbCr and the RGB output path.
- Fixed-latency, fully pipelined; accepts one pixel every clock.
- Delays de/hsync/vsync so they stay aligned with pixel data.
- Uses inferred fabric/DSP multipliers; no IP cores.

Parameters:
- CHROMA_OFFSET, 127: chroma bias removed from Cb and Cr. Matches the forward converter's 127 offset.

Ports:
- clk  in  1  pixel clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- de_in  in  1  data enable.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- pixel_in  in  24  {Y[23:16], Cb[15:8], Cr[7:0]}, unsigned.
- de_out  out  1  de_in delayed by 4 cycles.
- hsync_out  out  1  hsync_in delayed by 4 cycles.
- vsync_out  out  1  vsync_in delayed by 4 cycles.
- pixel_out  out  24  {R[23:16], G[15:8], B[7:0]}, unsigned.

Behaviour:
- Fixed-point coefficients, 14 fractional bits, unsigned:
  - KR_CR = 22970 (1.402)
  - KG_CB = 5638 (0.344136)
  - KG_CR = 11700 (0.714136)
  - KB_CB = 29032 (1.772)
- Stage 1: register Y (9b, zero-extended).
  - cb_s = Cb - CHROMA_OFFSET, signed 9b.
  - cr_s = Cr - CHROMA_OFFSET, signed 9b.
- Stage 2: four signed products, each cb_s or cr_s times a coefficient, 25b signed. Y is forwarded in parallel.
- Stage 3: 27b signed accumulators. RND = 8192.
  - r_acc = (Y<<14) + cr_s*KR_CR + RND
  - g_acc = (Y<<14) - cb_s*KG_CB - cr_s*KG_CR + RND
  - b_acc = (Y<<14) + cb_s*KB_CB + RND
- Stage 4, per channel:
  - Compute acc >>> 14 (arithmetic shift, floor).
  - Clamp: result < 0 -> 0; result > 255 -> 255; otherwise the 8-bit value.
  - Register the result into pixel_out.
- Latency: exactly 4 clocks, pixel_in -> pixel_out. The sync delay line is also 4 registers, so a pixel and its de/hsync/vsync appear on the same output cycle.
- Throughput: 1 pixel/clock. No stall and no backpressure. The pipeline always advances, whatever de_in is.
- Reset (async, no clock edge needed):
  - All sync delay registers and de_out/hsync_out/vsync_out go to 0.
  - pixel_out goes to 0.
  - Stage-1 registers clear to Y=0, cb_s=0, cr_s=0; downstream stages clear to 0. This makes the pipeline flush zeros, so pixel_out stays 0 after release until the first real sample arrives at cycle 4.
- Reset mid-frame: in-flight pixels are discarded; no partial pixel is emitted.
- Arithmetic boundaries:
  - Y=0/255 with extreme chroma must saturate, never wrap.
  - Cb=Cr=CHROMA_OFFSET gives R=G=B=Y exactly for all Y in 0..255.

Optional Feature:
- Macro YCBCR2RGB_BLANK_ZERO_EN.
- Defined: pixel_out is forced to 24'h000000 on every cycle where de_out=0. The forcing is applied at the stage-4 register, so latency is unchanged.
- Undefined: pixel_out always carries the converted value, including during blanking.
- Reset behaviour is identical in both builds.

Test Plan:
1. Neutral grey: pixel_in={128,127,127}, held -> pixel_out=24'h808080, first valid exactly 4 clocks after the input edge.
2. Positive saturation: {255,127,255} -> {255,164,255}. R clamps to 255; G = 2688512>>>14 = 164.
3. Negative saturation: {0,0,0} -> {0,134,0}. R and B clamp to 0; G = 2210118>>>14 = 134.
4. Sync alignment:
   - Stimulus: de_in high cycles 10-13, hsync_in pulse cycle 20, vsync_in pulse cycle 30.
   - Response: de_out high 14-17, hsync_out at 24, vsync_out at 34.
   - Pixels fed at cycles 10-13 appear at cycles 14-17.
5. Async reset:
   - Stimulus: stream data, assert rst between clock edges, release 3 cycles later, then apply {200,127,127}.
   - Response: all outputs go to 0 immediately, with no edge needed. Outputs stay 0 until 4 clocks after the new input, then 24'hC8C8C8.
6. Blanking:
   - Stimulus: {200,127,127} with de_in=0.
   - With YCBCR2RGB_BLANK_ZERO_EN: pixel_out=0.
   - Without: pixel_out=24'hC8C8C8.
   - When de_in rises, both builds output C8C8C8 with matching latency.

Source files
------------

// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: 4-stage full-range YCbCr 4:4:4 to RGB converter with aligned de/hsync/vsync.
// Define YCBCR2RGB_BLANK_ZERO_EN to force pixel_out to zero whenever de_out is low.
module ycbcr2rgb #(
   parameter int CHROMA_OFFSET = 127
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        de_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [23:0] pixel_in,
   output logic        de_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic [23:0] pixel_out
);
   localparam logic signed [15:0] KR_CR = 16'sd22970;
   localparam logic signed [15:0] KG_CB = 16'sd5638;
   localparam logic signed [15:0] KG_CR = 16'sd11700;
   localparam logic signed [15:0] KB_CB = 16'sd29032;
   localparam logic signed [26:0] RND   = 27'sd8192;
   logic        [8:0]      y1, y2;
   logic signed [8:0]      cb1, cr1;
   logic signed [24:0]     p_rcr, p_gcb, p_gcr, p_bcb;
   logic signed [26:0]     r_acc, g_acc, b_acc;
   logic        [3:0][2:0] sq;
   logic        [23:0]     rgb;
   // Floor of acc/2^14 is acc[26:14]; sign bit means <0, any of [25:22] set means >255.
   function automatic logic [7:0] clamp(input logic signed [26:0] a);
      return a[26] ? 8'd0 : |a[25:22] ? 8'hFF : a[21:14];
   endfunction
   assign rgb = {clamp(r_acc), clamp(g_acc), clamp(b_acc)};
   assign {de_out, hsync_out, vsync_out} = sq[3];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y1        <= '0;
         cb1       <= '0;
         cr1       <= '0;
         y2        <= '0;
         p_rcr     <= '0;
         p_gcb     <= '0;
         p_gcr     <= '0;
         p_bcb     <= '0;
         r_acc     <= '0;
         g_acc     <= '0;
         b_acc     <= '0;
         sq        <= '0;
         pixel_out <= '0;
      end else begin
         y1        <= {1'b0, pixel_in[23:16]};
         cb1       <= 9'({1'b0, pixel_in[15:8]} - 9'(CHROMA_OFFSET));
         cr1       <= 9'({1'b0, pixel_in[7:0]} - 9'(CHROMA_OFFSET));
         y2        <= y1;
         p_rcr     <= 25'(cr1) * 25'(KR_CR);
         p_gcb     <= 25'(cb1) * 25'(KG_CB);
         p_gcr     <= 25'(cr1) * 25'(KG_CR);
         p_bcb     <= 25'(cb1) * 25'(KB_CB);
         r_acc     <= $signed({4'b0, y2, 14'b0}) + 27'(p_rcr) + RND;
         g_acc     <= $signed({4'b0, y2, 14'b0}) - 27'(p_gcb) - 27'(p_gcr) + RND;
         b_acc     <= $signed({4'b0, y2, 14'b0}) + 27'(p_bcb) + RND;
         sq        <= {sq[2:0], de_in, hsync_in, vsync_in};
`ifdef YCBCR2RGB_BLANK_ZERO_EN
         pixel_out <= sq[2][2] ? rgb : 24'h000000;
`else
         pixel_out <= rgb;
`endif
      end
   end
endmodule

// File: tb/tb_ycbcr2rgb.sv
// tb_ycbcr2rgb: scoreboard bench; the driver queues expected outputs, a negedge monitor checks them.
module tb_ycbcr2rgb;
   logic        clk = 0, rst = 1;
   logic        de_in = 0, hsync_in = 0, vsync_in = 0;
   logic [23:0] pixel_in = '0;
   logic        de_out, hsync_out, vsync_out;
   logic [23:0] pixel_out;
   int          cyc = 0, checks = 0, errors = 0;
   typedef struct {
      int          cyc;
      logic        de, hs, vs;
      logic [23:0] px;
   } item_t;
   item_t sb[$];
   item_t e;
   ycbcr2rgb dut (
      .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .pixel_in(pixel_in), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
      .pixel_out(pixel_out)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [23:0] blank(input logic [23:0] v);
`ifdef YCBCR2RGB_BLANK_ZERO_EN
      return 24'h000000;
`else
      return v;
`endif
   endfunction
   always @(negedge clk) begin
      if (!rst && (de_out || hsync_out || vsync_out)) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output cyc=%0d got de/hs/vs=%b%b%b px=%h, none expected",
                     cyc, de_out, hsync_out, vsync_out, pixel_out);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.de != de_out || e.hs != hsync_out || e.vs != vsync_out || e.px != pixel_out) begin
               errors++;
               $display("FAIL output cyc=%0d got de/hs/vs=%b%b%b px=%h, expected cyc=%0d de/hs/vs=%b%b%b px=%h",
                        cyc, de_out, hsync_out, vsync_out, pixel_out, e.cyc, e.de, e.hs, e.vs, e.px);
            end
         end
      end
   end
   task automatic drive(input logic de, hs, vs, input logic [23:0] px, exp);
      de_in = de; hsync_in = hs; vsync_in = vs; pixel_in = px;
      if (!rst && (de || hs || vs)) sb.push_back('{cyc + 4, de, hs, vs, exp});
      @(posedge clk); #1;
   endtask
   task automatic check_zero(input string name);
      checks++;
      if ({de_out, hsync_out, vsync_out, pixel_out} != 27'd0) begin
         errors++;
         $display("FAIL %s got de/hs/vs=%b%b%b px=%h, expected all zero",
                  name, de_out, hsync_out, vsync_out, pixel_out);
      end
   endtask
   initial begin
      #3;
      check_zero("reset_state");
      repeat (2) @(posedge clk);
      #1 rst = 0;
      check_zero("after_release");
      // Neutral grey held, then saturation and boundary vectors.
      repeat (3) drive(1, 0, 0, {8'd128, 8'd127, 8'd127}, 24'h808080);
      drive(1, 0, 0, {8'd255, 8'd127, 8'd255}, {8'd255, 8'd164, 8'd255});
      drive(1, 0, 0, {8'd0, 8'd0, 8'd0}, {8'd0, 8'd134, 8'd0});
      drive(1, 0, 0, {8'd255, 8'd0, 8'd0}, 24'h4DFF1E);
      drive(1, 0, 0, {8'd0, 8'd255, 8'd255}, 24'hB300E3);
      drive(1, 0, 0, {8'd0, 8'd127, 8'd127}, 24'h000000);
      drive(1, 0, 0, {8'd255, 8'd127, 8'd127}, 24'hFFFFFF);
      drive(1, 0, 0, {8'd77, 8'd127, 8'd127}, 24'h4D4D4D);
      repeat (5) drive(0, 0, 0, 24'h0, 24'h0);
      // Sync alignment: de burst, hsync pulse, vsync pulse with blanking pixels.
      drive(1, 0, 0, {8'd10, 8'd127, 8'd127}, 24'h0A0A0A);
      drive(1, 0, 0, {8'd20, 8'd127, 8'd127}, 24'h141414);
      drive(1, 0, 0, {8'd30, 8'd127, 8'd127}, 24'h1E1E1E);
      drive(1, 0, 0, {8'd40, 8'd127, 8'd127}, 24'h282828);
      repeat (6) drive(0, 0, 0, 24'h0, 24'h0);
      drive(0, 1, 0, {8'd200, 8'd127, 8'd127}, blank(24'hC8C8C8));
      repeat (9) drive(0, 0, 0, 24'h0, 24'h0);
      drive(0, 0, 1, {8'd60, 8'd127, 8'd127}, blank(24'h3C3C3C));
      repeat (5) drive(0, 0, 0, 24'h0, 24'h0);
      // Blanking then de rising on the same colour.
      drive(0, 1, 0, {8'd200, 8'd127, 8'd127}, blank(24'hC8C8C8));
      drive(0, 1, 0, {8'd200, 8'd127, 8'd127}, blank(24'hC8C8C8));
      drive(1, 0, 0, {8'd200, 8'd127, 8'd127}, 24'hC8C8C8);
      drive(1, 0, 0, {8'd200, 8'd127, 8'd127}, 24'hC8C8C8);
      repeat (5) drive(0, 0, 0, 24'h0, 24'h0);
      // Async reset mid-stream: in-flight pixels must vanish.
      repeat (3) drive(1, 1, 1, {8'd90, 8'd10, 8'd240}, 24'h0);
      #2 rst = 1;
      #1 check_zero("async_reset_immediate");
      sb.delete();
      repeat (3) drive(1, 1, 0, {8'd90, 8'd10, 8'd240}, 24'h0);
      rst = 0;
      drive(1, 0, 0, {8'd200, 8'd127, 8'd127}, 24'hC8C8C8);
      check_zero("flush_1");
      drive(0, 0, 0, 24'h0, 24'h0);
      check_zero("flush_2");
      drive(0, 0, 0, 24'h0, 24'h0);
      check_zero("flush_3");
      for (int i = 0; i < 10 && sb.size() != 0; i++) drive(0, 0, 0, 24'h0, 24'h0);
      repeat (2) drive(0, 0, 0, 24'h0, 24'h0);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending outputs, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
